// File: rtl/clint_mh.sv
`timescale 1ns/1ps
// clint_mh: multi-hart core-local interruptor with per-hart msip/mtimecmp,
// a prescaled 64-bit mtime, registered bus reads and registered interrupts.
module clint_mh #(
    parameter int NUM_HARTS  = 4,
    parameter int TICK_DIV   = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  ack_o,
    output logic [NUM_HARTS-1:0]  timer_irq_o,
    output logic [NUM_HARTS-1:0]  software_irq_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    localparam logic [15:0] A_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] A_MTIME_HI = 16'hBFFC;

    logic [PW-1:0]         r_presc;
    logic                  w_tick;

    logic [DATA_WIDTH-1:0] r_mtime_lo;
    logic [DATA_WIDTH-1:0] r_mtime_hi;
    logic [DATA_WIDTH-1:0] w_lo_inc;
    logic                  w_carry;
    logic [63:0]           w_mtime;

    logic [NUM_HARTS-1:0]  r_msip;
    logic [DATA_WIDTH-1:0] r_cmp_lo [NUM_HARTS];
    logic [DATA_WIDTH-1:0] r_cmp_hi [NUM_HARTS];

    logic [15:0]           w_a;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_mt_lo_sel;
    logic                  w_mt_hi_sel;
    logic [NUM_HARTS-1:0]  w_msip_sel;
    logic [NUM_HARTS-1:0]  w_cmp_lo_sel;
    logic [NUM_HARTS-1:0]  w_cmp_hi_sel;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [NUM_HARTS-1:0]  w_tcmp;
    logic                  w_unused;

    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_data;
    logic [NUM_HARTS-1:0]  r_tirq;
    logic [NUM_HARTS-1:0]  r_sirq;

    assign w_a      = addr_i[15:0];
    assign w_unused = ^addr_i[31:16];
    assign w_rd     = req_i & ~we_i;
    assign w_wr     = req_i & we_i;

    // Prescaler: tick fires on the last count, so TICK_DIV=1 ticks every clock
    assign w_tick = (r_presc == PMAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_mt_lo_sel = (w_a == A_MTIME_LO);
    assign w_mt_hi_sel = (w_a == A_MTIME_HI);

    always_comb begin
        w_msip_sel   = '0;
        w_cmp_lo_sel = '0;
        w_cmp_hi_sel = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_msip_sel[h]   = (w_a == 16'(4 * h));
            w_cmp_lo_sel[h] = (w_a == 16'(16'h4000 + 8 * h));
            w_cmp_hi_sel[h] = (w_a == 16'(16'h4004 + 8 * h));
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_mt_lo_sel) begin
            w_rdata = r_mtime_lo;
        end
        if (w_mt_hi_sel) begin
            w_rdata = r_mtime_hi;
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_msip_sel[h]) begin
                w_rdata = DATA_WIDTH'(r_msip[h]);
            end
            if (w_cmp_lo_sel[h]) begin
                w_rdata = r_cmp_lo[h];
            end
            if (w_cmp_hi_sel[h]) begin
                w_rdata = r_cmp_hi[h];
            end
        end
    end

    assign w_lo_inc = r_mtime_lo + {{(DATA_WIDTH-1){1'b0}}, w_tick};
    assign w_carry  = w_tick & (&r_mtime_lo);
    assign w_mtime  = {r_mtime_hi, r_mtime_lo};

    // A lo write swallows the carry; a hi write discards it but lo keeps counting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtime_lo <= '0;
            r_mtime_hi <= '0;
        end else begin
            if (w_wr && w_mt_lo_sel) begin
                r_mtime_lo <= data_i;
            end else begin
                r_mtime_lo <= w_lo_inc;
            end
            if (w_wr && w_mt_hi_sel) begin
                r_mtime_hi <= data_i;
            end else if (!(w_wr && w_mt_lo_sel)) begin
                r_mtime_hi <= r_mtime_hi + {{(DATA_WIDTH-1){1'b0}}, w_carry};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_msip <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_cmp_lo[h] <= '1;
                r_cmp_hi[h] <= '1;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_wr && w_msip_sel[h]) begin
                    r_msip[h] <= data_i[0];
                end
                if (w_wr && w_cmp_lo_sel[h]) begin
                    r_cmp_lo[h] <= data_i;
                end
                if (w_wr && w_cmp_hi_sel[h]) begin
                    r_cmp_hi[h] <= data_i;
                end
            end
        end
    end

    always_comb begin
        w_tcmp = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_tcmp[h] = (w_mtime >= {r_cmp_hi[h], r_cmp_lo[h]});
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_data <= '0;
            r_tirq <= '0;
            r_sirq <= '0;
        end else begin
            r_ack  <= req_i;
            r_data <= w_rd ? w_rdata : '0;
            r_tirq <= w_tcmp;
            r_sirq <= r_msip;
        end
    end

    assign ack_o          = r_ack;
    assign data_o         = r_data;
    assign timer_irq_o    = r_tirq;
    assign software_irq_o = r_sirq;

endmodule

// File: doc/clint_mh.md
Name: clint_mh

Overview:
Multi-hart core-local interruptor. Generalises the single-hart timer/software-interrupt block to NUM_HARTS harts, each with its own msip and mtimecmp. Adds a programmable tick prescaler, a free-running writable 64-bit mtime, registered bus reads with an ack, and registered interrupt outputs. Sits on the peripheral bus beside the CSR unit; each hart's CSR file consumes its irq bits.

Parameters:
NUM_HARTS, 4, number of harts (1..16); sets the msip/mtimecmp bank count and irq vector width.
TICK_DIV, 1, clocks per mtime increment (>=1); 1 means increment every clock.
DATA_WIDTH, 32, bus data width; fixed at 32, and the 64-bit registers are split lo/hi.

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous, active-high reset
req_i  input  1  bus request, one-cycle strobe
we_i  input  1  write enable; qualified by req_i
addr_i  input  32  byte address; only addr_i[15:0] is decoded
data_i  input  32  write data
data_o  output  32  read data; valid when ack_o=1, else 0
ack_o  output  1  request completion, one cycle after req_i
timer_irq_o  output  NUM_HARTS  per-hart machine timer interrupt
software_irq_o  output  NUM_HARTS  per-hart machine software interrupt

Behaviour:
- Address map (addr_i[15:0]):
  - msip[h] at 0x0000+4h; only bit 0 is stored, and reads return {31'b0,bit}.
  - mtimecmp[h] lo at 0x4000+8h, hi at 0x4004+8h.
  - mtime lo at 0xBFF8, hi at 0xBFFC.
  - Harts h >= NUM_HARTS are unmapped.
- Reset values (asynchronous on rst_i=1):
  - mtime=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, every msip=0, prescaler=0.
  - ack_o=0, data_o=0, timer_irq_o=0, software_irq_o=0.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle the counter equals TICK_DIV-1. With TICK_DIV=1, tick is constantly 1.
- mtime:
  - Increments by 1 on every tick, independent of bus activity.
  - 64-bit wrap from all-ones to 0.
  - Carry from lo to hi occurs when lo==FFFF_FFFF and tick=1.
- mtime write precedence, when a write coincides with a tick:
  - Write to lo: lo<=data_i, hi is held, and the carry is suppressed.
  - Write to hi: hi<=data_i, lo still increments, and any carry is discarded.
  - The prescaler is unaffected by mtime writes.
- Bus handshake:
  - A request is accepted every cycle req_i=1; no back-pressure.
  - ack_o=1 exactly one cycle after each accepted request.
  - Read: data_o is sampled from register state at the request cycle, i.e. the pre-update value.
  - Write: data_o=0 in the ack cycle, and the register updates at the request edge.
  - Unmapped read returns 0; unmapped write is ignored. Both still ack.
- Interrupts (registered, one cycle after the state they reflect):
  - timer_irq_o[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare, using the current register values.
  - software_irq_o[h] <= msip[h].
  - After a write lowers mtimecmp[h] to <= mtime, timer_irq_o[h] rises two clocks after the write's request edge: register update, then irq register.
- Side effects:
  - The reset value of mtimecmp keeps timers disabled; no special zero rule.
  - A read has no side effects.
  - Writing mtimecmp lo then hi non-atomically may cause a transient irq; software handles this.
- Reset mid-operation: all state, including a pending ack, clears immediately and asynchronously. The first ack can follow a request in the first cycle after reset deasserts.

Test Plan:
- TICK_DIV=4, idle 40 clocks after reset -> mtime lo reads 10 (±1 per the sampling cycle), hi reads 0, and ack_o pulses for 1 cycle per read.
- Write mtime lo=FFFF_FFFE, hi=0 (TICK_DIV=1), then wait 3 clocks -> hi reads 1 and lo reads a small value, confirming the carry.
- Write mtimecmp[2]={0,0x100} with mtime running -> timer_irq_o=4'b0100 once mtime >= 0x100. Then write mtimecmp[2] hi=1 -> bit 2 clears 2 cycles later.
- Write msip[3]=0xFFFF_FFFF -> software_irq_o=4'b1000, and a read of msip[3] returns 0x1. Write 0 -> the bit clears next cycle.
- Write mtime lo=0x55 in the same cycle as a tick with lo=FFFF_FFFF -> lo=0x55 and hi unchanged. Read 0x4000+8*NUM_HARTS -> 0 with ack.
- Assert rst_i asynchronously mid-read -> ack_o and irqs drop immediately, and mtimecmp reads all-ones after release.
